// File: rtl/mem_slot_arbiter.sv
// rtl/mem_slot_arbiter.sv - phase-slotted IF/data arbiter for a single-ported unified memory
module mem_slot_arbiter #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10,
  parameter int BORROW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              phase,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam bit BORROW_EN = (BORROW != 0);

  state_t            state_q, state_d;
  logic [MEM_AW-1:0] lat_addr_q, lat_addr_d;
  logic              lat_we_q, lat_we_d;
  logic [3:0]        lat_be_q, lat_be_d;
  logic [31:0]       lat_wdata_q, lat_wdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic idle, busy, grant_if, grant_d, if_done, d_done;

  // Byte-offset and out-of-range address bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], if_addr[ADDR_W-1:MEM_AW+2],
                              d_addr[1:0], d_addr[ADDR_W-1:MEM_AW+2]};

  // Slot grant: the phase owner wins; the other side may borrow an empty slot.
  always_comb begin
    idle     = (state_q == IDLE);
    busy     = (state_q == BUSY_IF) || (state_q == BUSY_D);
    grant_if = idle & (phase ? if_req : (BORROW_EN & if_req & ~d_req));
    grant_d  = idle & (~phase ? d_req : (BORROW_EN & d_req & ~if_req));
    if_done  = mem_ready & (grant_if | (state_q == BUSY_IF));
    d_done   = mem_ready & (grant_d | (state_q == BUSY_D));
    if_stall = if_req & ~if_done;
    d_stall  = d_req & ~d_done;
  end

  // Memory request mux: latched fields while busy, otherwise the granted side.
  always_comb begin
    mem_en    = ~rst & (busy | grant_if | grant_d);
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (busy) begin
      mem_we    = lat_we_q;
      mem_be    = lat_be_q;
      mem_addr  = lat_addr_q;
      mem_wdata = lat_wdata_q;
    end else if (grant_if) begin
      mem_be    = 4'hF;
      mem_addr  = if_addr[MEM_AW+1:2];
    end else if (grant_d) begin
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr[MEM_AW+1:2];
      mem_wdata = d_wdata;
    end
  end

  // Next-state: latch a stalled grant, capture read data on completion.
  always_comb begin
    state_d     = state_q;
    lat_addr_d  = lat_addr_q;
    lat_we_d    = lat_we_q;
    lat_be_d    = lat_be_q;
    lat_wdata_d = lat_wdata_q;
    if_valid_d  = if_done;
    d_valid_d   = d_done;
    if_rdata_d  = if_done ? mem_rdata : if_rdata_q;
    d_rdata_d   = (d_done & ~mem_we) ? mem_rdata : d_rdata_q;
    if ((grant_if | grant_d) & ~mem_ready) begin
      state_d     = grant_if ? BUSY_IF : BUSY_D;
      lat_addr_d  = mem_addr;
      lat_we_d    = mem_we;
      lat_be_d    = mem_be;
      lat_wdata_d = mem_wdata;
    end else if (busy & mem_ready) begin
      state_d = IDLE;
    end
  end

  // State and output registers; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_addr_q  <= '0;
      lat_we_q    <= 1'b0;
      lat_be_q    <= 4'h0;
      lat_wdata_q <= 32'h0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      lat_addr_q  <= lat_addr_d;
      lat_we_q    <= lat_we_d;
      lat_be_q    <= lat_be_d;
      lat_wdata_q <= lat_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_valid = if_valid_q;
  assign d_valid  = d_valid_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// tb/tb_mem_slot_arbiter.sv - directed bench for mem_slot_arbiter (strict and borrow instances)
module tb_mem_slot_arbiter;

  logic        clk = 1'b0;
  logic        rst, phase, if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;

  logic [31:0] s_if_rdata, s_d_rdata, s_mem_wdata, b_if_rdata, b_d_rdata, b_mem_wdata;
  logic        s_if_valid, s_if_stall, s_d_valid, s_d_stall, s_mem_en, s_mem_we;
  logic        b_if_valid, b_if_stall, b_d_valid, b_d_stall, b_mem_en, b_mem_we;
  logic [3:0]  s_mem_be, b_mem_be;
  logic [9:0]  s_mem_addr, b_mem_addr;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_slot_arbiter #(.ADDR_W(32), .MEM_AW(10), .BORROW(0)) u_strict (
    .clk(clk), .rst(rst), .phase(phase),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(s_if_rdata), .if_valid(s_if_valid), .if_stall(s_if_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(s_d_rdata), .d_valid(s_d_valid), .d_stall(s_d_stall),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_be(s_mem_be), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_slot_arbiter #(.ADDR_W(32), .MEM_AW(10), .BORROW(1)) u_borrow (
    .clk(clk), .rst(rst), .phase(phase),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid), .if_stall(b_if_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(b_d_rdata), .d_valid(b_d_valid), .d_stall(b_d_stall),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    logic        rst, phase, if_req;
    logic [31:0] if_addr;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, mem_rdata;
    logic        mem_ready;
    logic        e_en, e_we;
    logic [3:0]  e_be;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_is, e_ds, e_iv;
    logic [31:0] e_ir;
    logic        e_dv;
    logic [31:0] e_dr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; phase = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
    d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_ready = 1;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    //            rst ph ifr if_addr       dr dwe be    d_addr        d_wdata       mem_rdata     rdy  en we be    addr    wdata         is ds iv ir            dv dr
    vecs[0] = '{1, 0, 0, 32'h0,        0, 0, 4'h0, 32'h0,       32'h0,       32'h0,       0,   0, 0, 4'h0, 10'h0,  32'h0,       0, 0, 0, 32'h0,       0, 32'h0};
    vecs[1] = '{0, 1, 1, 32'h10,       0, 0, 4'h0, 32'h0,       32'h0,       32'h00500093, 1,  1, 0, 4'hF, 10'h4,  32'h0,       0, 0, 1, 32'h00500093, 0, 32'h0};
    vecs[2] = '{0, 1, 0, 32'h0,        1, 0, 4'hF, 32'h44,      32'h0,       32'h0,       1,   0, 0, 4'h0, 10'h0,  32'h0,       0, 1, 0, 32'h00500093, 0, 32'h0};
    vecs[3] = '{0, 0, 0, 32'h0,        1, 0, 4'hF, 32'h44,      32'h0,       32'h11223344, 1,  1, 0, 4'hF, 10'h11, 32'h0,       0, 0, 0, 32'h00500093, 1, 32'h11223344};
    vecs[4] = '{0, 0, 0, 32'h0,        1, 1, 4'h5, 32'h1008,    32'hA5A5A5A5, 32'h77777777, 1, 1, 1, 4'h5, 10'h2,  32'hA5A5A5A5, 0, 0, 0, 32'h00500093, 1, 32'h11223344};
    vecs[5] = '{0, 1, 0, 32'h0,        1, 0, 4'hF, 32'h44,      32'h0,       32'h0,       1,   0, 0, 4'h0, 10'h0,  32'h0,       0, 1, 0, 32'h00500093, 0, 32'h11223344};
    vecs[6] = '{0, 0, 0, 32'h0,        0, 0, 4'h0, 32'h0,       32'h0,       32'h0,       1,   0, 0, 4'h0, 10'h0,  32'h0,       0, 0, 0, 32'h00500093, 0, 32'h11223344};
    vecs[7] = '{0, 0, 1, 32'h3FC,      0, 0, 4'h0, 32'h0,       32'h0,       32'h0,       1,   0, 0, 4'h0, 10'h0,  32'h0,       1, 0, 0, 32'h00500093, 0, 32'h11223344};
    vecs[8] = '{0, 1, 1, 32'h3FC,      0, 0, 4'h0, 32'h0,       32'h0,       32'h12345678, 1,  1, 0, 4'hF, 10'hFF, 32'h0,       0, 0, 1, 32'h12345678, 0, 32'h11223344};

    // Table-driven vectors against the strict instance.
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst; phase = vecs[i].phase; if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_be = vecs[i].d_be; d_addr = vecs[i].d_addr;
      d_wdata = vecs[i].d_wdata; mem_rdata = vecs[i].mem_rdata; mem_ready = vecs[i].mem_ready;
      #2;
      chk($sformatf("v%0d mem_en", i), 32'(s_mem_en), 32'(vecs[i].e_en));
      if (vecs[i].e_en) begin
        chk($sformatf("v%0d mem_we", i), 32'(s_mem_we), 32'(vecs[i].e_we));
        chk($sformatf("v%0d mem_be", i), 32'(s_mem_be), 32'(vecs[i].e_be));
        chk($sformatf("v%0d mem_addr", i), 32'(s_mem_addr), 32'(vecs[i].e_addr));
        if (vecs[i].e_we) chk($sformatf("v%0d mem_wdata", i), s_mem_wdata, vecs[i].e_wdata);
      end
      if (!vecs[i].rst) begin
        chk($sformatf("v%0d if_stall", i), 32'(s_if_stall), 32'(vecs[i].e_is));
        chk($sformatf("v%0d d_stall", i), 32'(s_d_stall), 32'(vecs[i].e_ds));
      end
      tick();
      chk($sformatf("v%0d if_valid", i), 32'(s_if_valid), 32'(vecs[i].e_iv));
      chk($sformatf("v%0d if_rdata", i), s_if_rdata, vecs[i].e_ir);
      chk($sformatf("v%0d d_valid", i), 32'(s_d_valid), 32'(vecs[i].e_dv));
      chk($sformatf("v%0d d_rdata", i), s_d_rdata, vecs[i].e_dr);
    end

    // Wait states: fetch held through 3 not-ready cycles while inputs wander.
    idle_inputs();
    mem_ready = 0; phase = 1; if_req = 1; if_addr = 32'h100;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        phase = ~phase; if_addr = 32'h200 + 32'(c * 4); d_req = 1;
      end
      if (c == 3) begin
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
      end
      #2;
      chk($sformatf("ws%0d mem_en", c), 32'(s_mem_en), 32'd1);
      chk($sformatf("ws%0d mem_addr", c), 32'(s_mem_addr), 32'h40);
      chk($sformatf("ws%0d mem_we", c), 32'(s_mem_we), 32'd0);
      chk($sformatf("ws%0d if_stall", c), 32'(s_if_stall), (c == 3) ? 32'd0 : 32'd1);
      chk($sformatf("ws%0d d_stall", c), 32'(s_d_stall), 32'(c > 0));
      tick();
      chk($sformatf("ws%0d if_valid", c), 32'(s_if_valid), 32'(c == 3));
      chk($sformatf("ws%0d d_valid", c), 32'(s_d_valid), 32'd0);
    end
    chk("ws if_rdata", s_if_rdata, 32'hDEADBEEF);
    // Back in IDLE on the IF slot: strict data request waits for its own slot.
    if_req = 0; phase = 1; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0; mem_rdata = 32'h0;
    #2;
    chk("ws post mem_en", 32'(s_mem_en), 32'd0);
    tick();
    phase = 0;
    #2;
    chk("ws slot mem_en", 32'(s_mem_en), 32'd1);
    tick();
    chk("ws slot d_valid", 32'(s_d_valid), 32'd1);

    // Borrow: establish known load data, then a store in the IF slot.
    idle_inputs();
    phase = 0; d_req = 1; d_be = 4'hF; d_addr = 32'h4; mem_rdata = 32'h5555AAAA;
    tick();
    chk("bw load d_rdata", b_d_rdata, 32'h5555AAAA);
    phase = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'hCAFEBEEF; mem_rdata = 32'h0BAD0BAD;
    #2;
    chk("bw mem_en", 32'(b_mem_en), 32'd1);
    chk("bw mem_we", 32'(b_mem_we), 32'd1);
    chk("bw mem_addr", 32'(b_mem_addr), 32'h8);
    chk("bw mem_be", 32'(b_mem_be), 32'h3);
    chk("bw mem_wdata", b_mem_wdata, 32'hCAFEBEEF);
    chk("bw strict mem_en", 32'(s_mem_en), 32'd0);
    tick();
    chk("bw d_valid", 32'(b_d_valid), 32'd1);
    chk("bw d_rdata kept", b_d_rdata, 32'h5555AAAA);

    // Contention: both sides request every cycle with zero-wait memory.
    idle_inputs();
    if_req = 1; if_addr = 32'h4; d_req = 1; d_be = 4'hF; d_addr = 32'h8; phase = 1;
    for (int c = 0; c < 6; c++) begin
      logic p;
      p = phase;
      mem_rdata = 32'h100 + 32'(c);
      #2;
      chk($sformatf("ct%0d s addr", c), 32'(s_mem_addr), p ? 32'd1 : 32'd2);
      chk($sformatf("ct%0d b addr", c), 32'(b_mem_addr), p ? 32'd1 : 32'd2);
      tick();
      chk($sformatf("ct%0d s if_valid", c), 32'(s_if_valid), 32'(p));
      chk($sformatf("ct%0d s d_valid", c), 32'(s_d_valid), 32'(!p));
      chk($sformatf("ct%0d b both", c), 32'(b_if_valid & b_d_valid), 32'd0);
      chk($sformatf("ct%0d b d_valid", c), 32'(b_d_valid), 32'(!p));
      phase = ~phase;
    end

    // Reset mid-access while BUSY_D.
    idle_inputs();
    phase = 0; d_req = 1; d_be = 4'hF; d_addr = 32'hC; mem_ready = 0;
    tick();
    rst = 1; mem_ready = 1; mem_rdata = 32'h99;
    #2;
    chk("rs mem_en", 32'(s_mem_en), 32'd0);
    tick();
    chk("rs d_valid", 32'(s_d_valid), 32'd0);
    chk("rs d_rdata", s_d_rdata, 32'h0);
    rst = 0; d_req = 0; mem_ready = 0;
    #2;
    chk("rs idle mem_en", 32'(s_mem_en), 32'd0);
    tick();
    chk("rs post d_valid", 32'(s_d_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_slot_arbiter.md
Name: mem_slot_arbiter

Overview:
- Consumer end of the fetch/data phase signal in the pipelined RISC-V core.
- Shares one single-ported unified memory between instruction fetch (IF) and load/store (MEM).
- The phase input selects which requester owns each memory slot.
- Variable-latency memory is supported through a mem_ready handshake.
- Returns registered read data and per-side stall indications to the pipeline.

Parameters:
- ADDR_W, 32: byte-address width of the IF and data request ports.
- MEM_AW, 10: word-address width driven to memory; mem_addr = addr[MEM_AW+1:2].
- BORROW, 0: 1 lets a requester use the other side's slot when that side has no request in the same cycle; 0 gives strict slotting.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- phase  input  1  slot owner: 1 = IF slot, 0 = data slot; toggles every cycle.
- if_req  input  1  fetch request; held until if_valid.
- if_addr  input  ADDR_W  fetch byte address.
- if_rdata  output  32  fetched instruction, registered.
- if_valid  output  1  one-cycle pulse: if_rdata updated.
- if_stall  output  1  if_req pending and not completing this cycle.
- d_req  input  1  data request; held until d_valid.
- d_we  input  1  1 = store.
- d_be  input  4  store byte enables.
- d_addr  input  ADDR_W  data byte address.
- d_wdata  input  32  store data.
- d_rdata  output  32  load data, registered.
- d_valid  output  1  one-cycle pulse: access done (loads and stores).
- d_stall  output  1  d_req pending and not completing this cycle.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write.
- mem_be  output  4  memory byte enables.
- mem_addr  output  MEM_AW  memory word address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data; valid when mem_ready=1.
- mem_ready  input  1  memory completes the current access this cycle.

Behaviour:
- Reset: state IDLE; if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, latched request cleared.
  - mem_en=0 whenever rst=1, regardless of state.
- States:
  - IDLE: no access outstanding.
  - BUSY_IF: fetch access waiting for mem_ready.
  - BUSY_D: data access waiting for mem_ready.
- IDLE, grant selection:
  - owner = phase ? IF : DATA.
  - Grant goes to the owner if the owner's req=1.
  - If BORROW=1 and the owner's req=0, grant goes to the other side if its req=1.
  - No grant: mem_en=0.
- IDLE with grant, combinational in the same cycle:
  - mem_en=1; mem_addr/mem_we/mem_be/mem_wdata come from the granted side.
  - IF grant forces mem_we=0, mem_be=4'hF.
- Grant completes (mem_ready=1) in the same cycle:
  - At the clock edge, capture mem_rdata into if_rdata, or into d_rdata when d_we=0.
  - Pulse the matching valid in the next cycle. State stays IDLE.
- Grant with mem_ready=0:
  - Latch the granted request fields; go to BUSY_IF or BUSY_D.
- BUSY_x:
  - mem_en=1 with the latched fields, held stable regardless of phase or requester input changes.
  - On mem_ready=1: capture data as above, pulse valid next cycle, return to IDLE.
- Phase is ignored while busy. After returning to IDLE, slot selection uses the current phase, with no catch-up.
- Store completion: d_valid pulses; d_rdata is unchanged.
- Latency:
  - Zero-wait memory: valid rises 1 cycle after the granting cycle.
  - Each wait cycle adds 1.
- if_valid and d_valid are never high in the same cycle. Only one access is outstanding at a time.
- Back-to-back: a new grant may issue in the same cycle a valid pulses, if the FSM is IDLE and that cycle's slot owner requests.
- Stall outputs:
  - if_stall = if_req & ~(IF access completing this cycle).
  - d_stall defined identically for the data side.
  - Both are combinational.
- Requester drops req before its valid:
  - In IDLE, the request is simply not granted.
  - In BUSY_x, the access completes anyway; the valid still pulses and the requester discards it.
- Address bits [1:0] and bits above MEM_AW+1 are ignored; there is no misalignment checking.
- rst asserted in BUSY_x: access abandoned, IDLE next cycle, no valid pulse, data registers cleared.

Test Plan:
- Zero-wait fetch: mem_ready=1, phase=1, if_req=1, if_addr=0x0000_0010 → mem_en=1, mem_addr=4, mem_we=0 that cycle; mem_rdata=0x00500093 → if_valid=1 and if_rdata=0x00500093 next cycle.
- Strict slotting: BORROW=0, phase=1, d_req=1 only → mem_en=0, d_stall=1; next cycle phase=0 → grant, d_valid one cycle later.
- Borrow: BORROW=1, phase=1, if_req=0, d_req=1, d_we=1, d_be=4'b0011, d_addr=0x20, d_wdata=0xCAFE_BEEF → same-cycle mem_we=1, mem_addr=8, mem_be=3; d_valid next cycle; d_rdata unchanged.
- Wait states: fetch granted with mem_ready low 3 cycles while phase toggles and if_addr changes → mem_addr held at the latched value for 4 cycles total; if_valid 1 cycle after mem_ready; no data grant while busy.
- Contention: if_req=d_req=1 continuously with zero-wait memory → grants alternate IF/D each cycle following phase; valids alternate; never simultaneous.
- Reset mid-access: rst=1 during BUSY_D → mem_en=0 that cycle, no d_valid, d_rdata=0, state IDLE after rst drops.
